// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader
//   Three-channel PWM generator with a linear fade engine, feeding the
//   RGB0PWM..RGB2PWM inputs of an SB_RGB_DRV LED stage. A host loads a target
//   colour over a valid/ready handshake; the block either jumps to it or ramps
//   every channel one duty step per fade tick. Duty changes take effect only at
//   PWM period boundaries, so a period never mixes old and new duty.
//
// Parameters
//   PWM_BITS  duty resolution; PWM period is 2**PWM_BITS-1 clk cycles
//   FADE_DIV  clk cycles per fade tick (>= 1)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tgt        target duty, ch0 in the low PWM_BITS, ch2 in the top PWM_BITS
//   instant    sampled with tgt: 1 = jump to target, 0 = fade
//   tgt_valid  host offers tgt/instant
//   tgt_ready  block can accept (high while idle)
//   done       one-cycle pulse when all channels reach the accepted target
//   pwm        pwm[i] drives RGBiPWM of the LED driver

module rgb_pwm_fader #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned FADE_DIV = 31_250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3*PWM_BITS-1:0]   tgt,
    input  logic                    instant,
    input  logic                    tgt_valid,
    output logic                    tgt_ready,
    output logic                    done,
    output logic [2:0]              pwm
);

    // Last counter value of a period: 2**PWM_BITS-2.
    localparam logic [PWM_BITS-1:0] CTR_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

    localparam int unsigned          TICK_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(FADE_DIV - 1);

    typedef enum logic {
        IDLE,
        FADE
    } state_t;

    state_t                         state;
    logic [PWM_BITS-1:0]            ctr;
    logic [TICK_W-1:0]              tick;
    logic [2:0][PWM_BITS-1:0]       duty_cur;
    logic [2:0][PWM_BITS-1:0]       duty_act;
    logic [2:0][PWM_BITS-1:0]       tgt_reg;
    logic [2:0][PWM_BITS-1:0]       tgt_in;
    logic [2:0][PWM_BITS-1:0]       duty_step;
    logic                           step_at_tgt;

    assign tgt_in    = tgt;
    assign tgt_ready = (state == IDLE);

    // One step of every channel toward the latched target; channels already
    // there hold, so a step can never overshoot.
    always_comb begin
        duty_step = duty_cur;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            if (duty_cur[ch] < tgt_reg[ch]) begin
                duty_step[ch] = duty_cur[ch] + 1'b1;
            end else if (duty_cur[ch] > tgt_reg[ch]) begin
                duty_step[ch] = duty_cur[ch] - 1'b1;
            end
        end
        step_at_tgt = (duty_step == tgt_reg);
    end

    // PWM period counter and output stage. duty_act is only refreshed on the
    // last count, so the new duty starts cleanly from ctr==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr      <= '0;
            duty_act <= '0;
            pwm      <= '0;
        end else begin
            if (ctr == CTR_MAX) begin
                ctr      <= '0;
                duty_act <= duty_cur;
            end else begin
                ctr <= ctr + 1'b1;
            end
            for (int unsigned ch = 0; ch < 3; ch++) begin
                pwm[ch] <= (ctr < duty_act[ch]);
            end
        end
    end

    // Load / fade control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick     <= '0;
            duty_cur <= '0;
            tgt_reg  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_reg <= tgt_in;
                        if (instant || (tgt_in == duty_cur)) begin
                            duty_cur <= tgt_in;
                            done     <= 1'b1;
                        end else begin
                            tick  <= '0;
                            state <= FADE;
                        end
                    end
                end
                FADE: begin
                    if (tick == TICK_LAST) begin
                        tick     <= '0;
                        duty_cur <= duty_step;
                        if (step_at_tgt) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader
//   Bench for rgb_pwm_fader with PWM_BITS=8, FADE_DIV=4. Accepted targets push
//   the expected done cycle; period boundaries push the expected duty, and the
//   high count of each full period is compared against it.

module tb_rgb_pwm_fader;

    localparam int unsigned FD  = 4;
    localparam int unsigned PER = 255;

    logic        clk;
    logic        rst_n;
    logic [23:0] tgt;
    logic        instant;
    logic        tgt_valid;
    logic        tgt_ready;
    logic        done;
    logic [2:0]  pwm;

    rgb_pwm_fader #(
        .PWM_BITS (8),
        .FADE_DIV (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgt       (tgt),
        .instant   (instant),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .done      (done),
        .pwm       (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Clock edges since reset release.
    int unsigned kcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) kcnt <= 0;
        else        kcnt <= kcnt + 1;
    end

    // Current load segment: duty before the accept, target, accept edge, mode.
    logic [23:0] seg_start;
    logic [23:0] seg_tgt;
    int unsigned seg_k;
    bit          seg_inst;
    int unsigned k_acc;
    int unsigned last_done_k;

    int unsigned done_q[$];
    logic [23:0] pwm_q[$];
    int unsigned cnt[3];
    bit          armed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected duty_cur after edge k: linear walk from seg_start toward seg_tgt,
    // one step per FD edges, never past the target.
    function automatic logic [23:0] model_duty(input int unsigned k);
        logic [23:0] r;
        int unsigned n, s, t, d;
        r = seg_tgt;
        if (k < seg_k) return seg_start;
        if (seg_inst) return seg_tgt;
        n = (k - seg_k) / FD;
        for (int ch = 0; ch < 3; ch++) begin
            s = seg_start[ch*8 +: 8];
            t = seg_tgt[ch*8 +: 8];
            d = (t > s) ? (t - s) : (s - t);
            if (d > n) d = n;
            s = (t > s) ? (s + d) : (s - d);
            r[ch*8 +: 8] = 8'(s);
        end
        return r;
    endfunction

    // Output monitor: done pulses and per-period high counts.
    always @(negedge clk) begin
        if (!rst_n) begin
            armed = 1'b0;
            done_q.delete();
            pwm_q.delete();
        end else begin
            if (done) begin
                if (done_q.size() == 0) begin
                    check_eq("done_unexpected", done, 0);
                end else begin
                    check_eq("done_cycle", kcnt, done_q.pop_front());
                end
            end
            if (armed) begin
                for (int ch = 0; ch < 3; ch++) cnt[ch] += pwm[ch];
            end
            if ((kcnt % PER) == 0 && kcnt != 0) begin
                if (armed && pwm_q.size() != 0) begin
                    logic [23:0] e;
                    e = pwm_q.pop_front();
                    check_eq("pwm0_high", cnt[0], e[7:0]);
                    check_eq("pwm1_high", cnt[1], e[15:8]);
                    check_eq("pwm2_high", cnt[2], e[23:16]);
                end
                pwm_q.push_back(model_duty(kcnt - 1));
                for (int ch = 0; ch < 3; ch++) cnt[ch] = 0;
                armed = 1'b1;
            end
        end
    end

    // Offer a target, wait for it to be taken, record expectations.
    // Returns 1 time unit after the accepting edge.
    task automatic send(input logic [23:0] t, input logic inst);
        int unsigned n, dmax, d, a, b;
        tgt       = t;
        instant   = inst;
        tgt_valid = 1'b1;
        n = 0;
        while (!tgt_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!tgt_ready) begin
            check_eq("accept_timeout", tgt_ready, 1);
            tgt_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        k_acc     = kcnt;
        seg_start = model_duty(k_acc - 1);
        seg_tgt   = t;
        seg_k     = k_acc;
        seg_inst  = inst;
        dmax = 0;
        for (int ch = 0; ch < 3; ch++) begin
            a = seg_start[ch*8 +: 8];
            b = t[ch*8 +: 8];
            d = (a > b) ? (a - b) : (b - a);
            if (d > dmax) dmax = d;
        end
        last_done_k = (inst || dmax == 0) ? k_acc : k_acc + FD * dmax;
        done_q.push_back(last_done_k);
        tgt_valid = 1'b0;
    endtask

    // Wait for the done pulse; optionally require tgt_ready low until then.
    task automatic wait_idle(input bit busy_chk);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!done && n < 4000) begin
            if (busy_chk) check_eq("busy_ready", tgt_ready, 0);
            @(negedge clk);
            n++;
        end
        if (done) check_eq("done_ready", tgt_ready, 1);
        else      check_eq("done_timeout", done, 1);
    endtask

    task automatic clear_model();
        seg_start = '0;
        seg_tgt   = '0;
        seg_k     = 0;
        seg_inst  = 1'b0;
    endtask

    initial begin
        clear_model();
        rst_n     = 1'b0;
        tgt       = 24'hABCDEF;
        instant   = 1'b1;
        tgt_valid = 1'b1;

        // Reset with a target offered.
        repeat (5) begin
            @(negedge clk);
            check_eq("rst_pwm", pwm, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_ready", tgt_ready, 1);
        end
        tgt_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);

        // Instant load ch0=0, ch1=128, ch2=255.
        send({8'd255, 8'd128, 8'd0}, 1'b1);
        wait_idle(1'b0);
        repeat (700) @(negedge clk);

        // Fade ch0 0 -> 10 from zero.
        send(24'd0, 1'b1);
        wait_idle(1'b0);
        send({8'd0, 8'd0, 8'd10}, 1'b0);
        wait_idle(1'b1);
        repeat (300) @(negedge clk);

        // {50,50,50} -> {40,60,50}: ch0 falls, ch1 rises, ch2 holds.
        send({8'd50, 8'd50, 8'd50}, 1'b1);
        wait_idle(1'b0);
        send({8'd50, 8'd60, 8'd40}, 1'b0);
        wait_idle(1'b1);
        repeat (300) @(negedge clk);

        // Long fade spanning periods; second target offered while busy.
        send({8'd200, 8'd30, 8'd100}, 1'b0);
        begin
            int unsigned d1;
            d1 = last_done_k;
            send({8'd60, 8'd250, 8'd5}, 1'b0);
            check_eq("accept_at_ready", k_acc, d1 + 1);
        end
        wait_idle(1'b0);
        repeat (300) @(negedge clk);

        // Reset in the middle of a fade.
        send({8'd200, 8'd200, 8'd200}, 1'b1);
        wait_idle(1'b0);
        repeat (300) @(negedge clk);
        send({8'd10, 8'd10, 8'd10}, 1'b0);
        repeat (100) @(negedge clk);
        #2;
        rst_n     = 1'b0;
        tgt_valid = 1'b1;
        #1;
        check_eq("midrst_pwm", pwm, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_ready", tgt_ready, 1);
        repeat (5) begin
            @(negedge clk);
            check_eq("midrst_hold_pwm", pwm, 0);
        end
        tgt_valid = 1'b0;
        clear_model();
        rst_n = 1'b1;
        repeat (600) @(negedge clk);

        // Counter phase after release.
        send({8'd200, 8'd100, 8'd0}, 1'b1);
        wait_idle(1'b0);
        repeat (600) @(negedge clk);

        check_eq("done_pending", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
